// File: rtl/svf_multichannel_if.sv
// Port bundle for svf_multichannel: per-channel samples, coefficients and modes in,
// filtered samples and frame status out. Widths follow the filter's parameters.
interface svf_multichannel_if #(
  parameter int SAMPLE_BITS = 16,
  parameter int CHANNELS    = 4,
  parameter int COEF_BITS   = 18
);
  logic                            sample_clk;
  logic [CHANNELS*SAMPLE_BITS-1:0] in;
  logic [CHANNELS*COEF_BITS-1:0]   F;
  logic [CHANNELS*COEF_BITS-1:0]   Q1;
  logic [CHANNELS*2-1:0]           mode;
  logic [CHANNELS-1:0]             clear;
  logic [CHANNELS*SAMPLE_BITS-1:0] out;
  logic                            out_valid;
  logic                            busy;
  logic                            overrun;

  modport master (
    output sample_clk, in, F, Q1, mode, clear,
    input  out, out_valid, busy, overrun
  );

  modport slave (
    input  sample_clk, in, F, Q1, mode, clear,
    output out, out_valid, busy, overrun
  );
endinterface

// File: rtl/svf_multichannel.sv
// Time-multiplexed Chamberlin state-variable filter, CHANNELS voices through one multiplier.
// Define SVF_STATE_SAT_EN to saturate the lp/bp state sums instead of letting them wrap.
module svf_multichannel #(
  parameter int SAMPLE_BITS = 16,
  parameter int CHANNELS    = 4,
  parameter int COEF_BITS   = 18
) (
  input logic               clk,
  input logic               rst,
  svf_multichannel_if.slave bus
);
  localparam int W  = SAMPLE_BITS + 3;
  localparam int PW = W + COEF_BITS;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0]       LAST_CH = CW'(CHANNELS - 1);
  localparam logic signed [W-1:0] OUT_MAX = W'((2 ** (SAMPLE_BITS - 1)) - 1);
  localparam logic signed [W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   ch_reg, ch_next;
  logic            sc_hist_reg, busy_reg, out_valid_reg, overrun_reg;
  logic            edge_seen, start;

  logic signed [SAMPLE_BITS-1:0] in_ch [CHANNELS];
  logic signed [COEF_BITS-1:0]   f_ch [CHANNELS];
  logic signed [COEF_BITS-1:0]   q1_ch [CHANNELS];
  logic [1:0]                    mode_ch [CHANNELS];

  logic signed [SAMPLE_BITS-1:0] in_frm_reg [CHANNELS];
  logic signed [COEF_BITS-1:0]   f_frm_reg [CHANNELS];
  logic signed [COEF_BITS-1:0]   q1_frm_reg [CHANNELS];
  logic [1:0]                    mode_frm_reg [CHANNELS];
  logic [CHANNELS-1:0]           clear_frm_reg;

  logic signed [W-1:0]           lp_mem [CHANNELS];
  logic signed [W-1:0]           bp_mem [CHANNELS];
  logic signed [SAMPLE_BITS-1:0] out_reg [CHANNELS];

  logic signed [W-1:0] q_reg, lp_new_reg, hp_reg, bp_new_reg, notch_reg;
  logic signed [W-1:0] lp_cur, bp_cur, in_sext, prod_f, lp_new, hp, bp_new, sel;
  logic signed [W-1:0] mul_a;
  logic signed [COEF_BITS-1:0] mul_b;
  logic signed [PW-1:0] product;

  function automatic logic signed [W-1:0] add_state(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
`ifdef SVF_STATE_SAT_EN
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) add_state = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else add_state = s[W-1:0];
`else
    add_state = a + b;
`endif
  endfunction

  function automatic logic signed [SAMPLE_BITS-1:0] clamp_out(input logic signed [W-1:0] v);
    if (v > OUT_MAX)      clamp_out = OUT_MAX[SAMPLE_BITS-1:0];
    else if (v < OUT_MIN) clamp_out = OUT_MIN[SAMPLE_BITS-1:0];
    else                  clamp_out = v[SAMPLE_BITS-1:0];
  endfunction

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign in_ch[gi]   = bus.in[gi*SAMPLE_BITS +: SAMPLE_BITS];
      assign f_ch[gi]    = bus.F[gi*COEF_BITS +: COEF_BITS];
      assign q1_ch[gi]   = bus.Q1[gi*COEF_BITS +: COEF_BITS];
      assign mode_ch[gi] = bus.mode[gi*2 +: 2];
      assign bus.out[gi*SAMPLE_BITS +: SAMPLE_BITS] = out_reg[gi];
    end
  endgenerate

  assign edge_seen     = bus.sample_clk & ~sc_hist_reg;
  assign start         = edge_seen & ~busy_reg;
  assign bus.busy      = busy_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.overrun   = overrun_reg;

  // A cleared channel runs its whole frame on zero state, so every phase sees the mux.
  assign lp_cur  = clear_frm_reg[ch_reg] ? '0 : lp_mem[ch_reg];
  assign bp_cur  = clear_frm_reg[ch_reg] ? '0 : bp_mem[ch_reg];
  assign in_sext = W'(in_frm_reg[ch_reg]);

  always_comb begin
    mul_a = bp_cur;
    mul_b = q1_frm_reg[ch_reg];
    case (state_reg)
      P1:      mul_b = f_frm_reg[ch_reg];
      P2:      begin mul_a = hp_reg; mul_b = f_frm_reg[ch_reg]; end
      default: ;
    endcase
  end

  assign product = mul_a * mul_b;
  assign prod_f  = W'(product >>> (COEF_BITS - 1));
  assign lp_new  = add_state(lp_cur, prod_f);
  assign hp      = in_sext - lp_new - q_reg;
  assign bp_new  = add_state(bp_cur, prod_f);

  always_comb begin
    sel = lp_new_reg;
    case (mode_frm_reg[ch_reg])
      2'b01:   sel = hp_reg;
      2'b10:   sel = bp_new_reg;
      2'b11:   sel = notch_reg;
      default: sel = lp_new_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    case (state_reg)
      IDLE: if (start) begin state_next = P0; ch_next = '0; end
      P0:   state_next = P1;
      P1:   state_next = P2;
      P2:   state_next = P3;
      P3: begin
        if (ch_reg == LAST_CH) state_next = IDLE;
        else begin state_next = P0; ch_next = ch_reg + CW'(1); end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_hist_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      clear_frm_reg <= '0;
      q_reg         <= '0;
      lp_new_reg    <= '0;
      hp_reg        <= '0;
      bp_new_reg    <= '0;
      notch_reg     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        in_frm_reg[i]   <= '0;
        f_frm_reg[i]    <= '0;
        q1_frm_reg[i]   <= '0;
        mode_frm_reg[i] <= '0;
        lp_mem[i]       <= '0;
        bp_mem[i]       <= '0;
        out_reg[i]      <= '0;
      end
    end else begin
      sc_hist_reg   <= bus.sample_clk;
      out_valid_reg <= 1'b0;
      overrun_reg   <= edge_seen & busy_reg;
      if (start) begin
        busy_reg      <= 1'b1;
        clear_frm_reg <= bus.clear;
        for (int i = 0; i < CHANNELS; i++) begin
          in_frm_reg[i]   <= in_ch[i];
          f_frm_reg[i]    <= f_ch[i];
          q1_frm_reg[i]   <= q1_ch[i];
          mode_frm_reg[i] <= mode_ch[i];
        end
      end
      case (state_reg)
        P0: q_reg <= W'(product >>> (COEF_BITS - 2));
        P1: begin lp_new_reg <= lp_new; hp_reg <= hp; end
        P2: begin bp_new_reg <= bp_new; notch_reg <= hp_reg + lp_new_reg; end
        P3: begin
          lp_mem[ch_reg]  <= lp_new_reg;
          bp_mem[ch_reg]  <= bp_new_reg;
          out_reg[ch_reg] <= clamp_out(sel);
          if (ch_reg == LAST_CH) begin
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_svf_multichannel.sv
// Directed-vector bench for svf_multichannel: hand-computed filter steps, clamp, overrun and reset.
module tb_svf_multichannel;
  localparam int SB = 16;
  localparam int CH = 4;
  localparam int CB = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  svf_multichannel_if #(.SAMPLE_BITS(SB), .CHANNELS(CH), .COEF_BITS(CB)) bus ();
  svf_multichannel #(.SAMPLE_BITS(SB), .CHANNELS(CH), .COEF_BITS(CB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [CH*SB-1:0] smp;
    logic [CB-1:0]    f;
    logic [CB-1:0]    q1;
    logic [2*CH-1:0]  mode;
    logic [CH-1:0]    clr;
    int               exp_out [CH];
  } vec_t;

  vec_t vecs [7];
  int   prev [CH];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int i0, input int i1, input int i2, input int i3,
                               input logic [CB-1:0] f, input logic [CB-1:0] q1,
                               input logic [7:0] m, input logic [3:0] c,
                               input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.smp  = {16'(i3), 16'(i2), 16'(i1), 16'(i0)};
    v.f    = f;
    v.q1   = q1;
    v.mode = m;
    v.clr  = c;
    v.exp_out[0] = e0; v.exp_out[1] = e1; v.exp_out[2] = e2; v.exp_out[3] = e3;
    return v;
  endfunction

  function automatic int slot(input int c);
    logic signed [SB-1:0] s;
    s = bus.out[c*SB +: SB];
    return int'(s);
  endfunction

  task automatic drive(input vec_t v);
    bus.in         = v.smp;
    bus.F          = {CH{v.f}};
    bus.Q1         = {CH{v.q1}};
    bus.mode       = v.mode;
    bus.clear      = v.clr;
    bus.sample_clk = 1'b1;
  endtask

  // One frame: start edge E, then watch edges E+1..E+4*CH+4.
  task automatic run_frame(input vec_t v, input bit inject, input string tag);
    int vcount, vat, busy_err, ov_count;
    vcount = 0; vat = 0; busy_err = 0; ov_count = 0;
    @(negedge clk);
    drive(v);
    @(posedge clk); #1;
    check({tag, " busy_rise"}, 32'(bus.busy), 1);
    bus.sample_clk = 1'b0;
    bus.in    = {$urandom, $urandom};
    bus.clear = ~v.clr;
    bus.mode  = ~v.mode;
    bus.F     = '0;
    for (int k = 1; k <= 4*CH + 4; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        vcount++;
        if (k == 4*CH) vat = 1;
      end
      if (bus.busy !== ((k < 4*CH) ? 1'b1 : 1'b0)) busy_err++;
      if (bus.overrun === 1'b1) ov_count++;
      if (k == 4) begin
        check({tag, " slot0_at_E+4"}, slot(0), v.exp_out[0]);
        check({tag, " slot_last_hold"}, slot(CH-1), prev[CH-1]);
        if (inject) bus.sample_clk = 1'b1;
      end
      if (k == 8) bus.sample_clk = 1'b0;
    end
    check({tag, " out_valid_count"}, vcount, 1);
    check({tag, " out_valid_at_E+16"}, vat, 1);
    check({tag, " busy_profile_errors"}, busy_err, 0);
    check({tag, " overrun_count"}, ov_count, inject ? 1 : 0);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("%s out%0d", tag, c), slot(c), v.exp_out[c]);
      prev[c] = v.exp_out[c];
    end
    $display("frame %s: out = %0d %0d %0d %0d", tag, slot(0), slot(1), slot(2), slot(3));
  endtask

  initial begin
    // modes ch3..ch0: notch, bandpass, highpass, lowpass; F = 0.125, Q1 = 1.0
    vecs[0] = mkv(1000, 1000, -1001, 1000, 18'h04000, 18'h10000, 8'b11_10_01_00, 4'b0000,
                  0, 1000, -126, 1000);
    vecs[1] = mkv(1000, 1000, -1001, 1000, 18'h04000, 18'h10000, 8'b11_10_01_00, 4'b0000,
                  15, 860, -234, 875);
    vecs[2] = mkv(1000, 1000, -1001, 1000, 18'h04000, 18'h10000, 8'b11_10_01_00, 4'b0000,
                  44, 724, -325, 768);
    vecs[3] = mkv(1000, 1000, -1001, 1000, 18'h04000, 18'h10000, 8'b11_10_01_00, 4'b0010,
                  84, 1000, -399, 678);
    // modes ch3..ch0: notch, highpass, lowpass, lowpass; F ~ 1.0, Q1 = 0
    vecs[4] = mkv(32767, -32768, -32768, 32767, 18'h1FFFF, 18'h00000, 8'b11_01_00_00, 4'b1111,
                  0, 0, -32768, 32767);
    vecs[5] = mkv(32767, -32768, -32768, 32767, 18'h1FFFF, 18'h00000, 8'b11_01_00_00, 4'b0000,
                  32765, -32768, 0, 32767);
    vecs[6] = mkv(32767, -32768, -32768, 32767, 18'h1FFFF, 18'h00000, 8'b11_01_00_00, 4'b0000,
                  32767, -32768, 32767, 32767);
    for (int c = 0; c < CH; c++) prev[c] = 0;

    bus.sample_clk = 1'b0;
    bus.in = '0; bus.F = '0; bus.Q1 = '0; bus.mode = '0; bus.clear = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 0);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset overrun", 32'(bus.overrun), 0);
    check("reset out_nonzero", 32'(bus.out != '0), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));
    run_frame(vecs[4], 1'b1, "overrun");
    for (int i = 4; i < 7; i++) run_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Abort a frame with reset partway through channel 1.
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk); #1;
    bus.sample_clk = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset busy", 32'(bus.busy), 0);
    check("midreset out_valid", 32'(bus.out_valid), 0);
    check("midreset out_nonzero", 32'(bus.out != '0), 0);
    $display("midframe reset: busy=%0d out=%h", bus.busy, bus.out);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < CH; c++) prev[c] = 0;
    run_frame(vecs[0], 1'b0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
